cell_test_sequencer: RTL and testbench
======================================

Name: cell_test_sequencer

Overview:
Self-test controller for the testwafer's standard-cell instances (AND/NAND/NOR/OR/XOR/XNOR, AOI/OAI, MUX, INV/BUF).
- Selects one cell under test through an external input mux.
- Walks every input vector of that cell and waits a programmable settle time per vector.
- Samples the cell's Y output and compares it with a software-supplied truth table.
- Reports the mismatch count and the first failing vector to the Wishbone register wrapper.

Parameters:
NCELLS, 22, number of cell Y outputs observed (one per cell instance)
SELW, 5, width of cell select index (must satisfy 2^SELW >= NCELLS)
SETTLE_W, 8, width of settle-cycle count

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous active-high reset
start_i  input  1  single-cycle start pulse
abort_i  input  1  abort current run
cell_sel_i  input  SELW  index of cell under test
nin_i  input  3  number of cell inputs used, 1..4
exp_tt_i  input  16  expected Y; bit v is Y for input vector v
settle_i  input  SETTLE_W  extra wait cycles per vector (S)
cell_y_i  input  NCELLS  Y outputs of all cells under test
cell_in_o  output  4  drives A, B, C, D/S of the selected cell (bit0 = A)
cell_sel_o  output  SELW  latched cell index to the input mux
busy_o  output  1  run in progress
done_o  output  1  run finished; level signal
pass_o  output  1  done with zero mismatches
cfg_err_o  output  1  illegal configuration at start
err_cnt_o  output  5  mismatch count, 0..16
fail_vec_o  output  4  first failing vector
fail_valid_o  output  1  fail_vec_o is meaningful

Behaviour:
Interface:
- One clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.

Reset (wb_rst_i = 1), including mid-run:
- All outputs go to 0. FSM goes to IDLE.

FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.

Start:
- start_i is accepted only in IDLE or DONE. It is ignored while busy.
- On an accepted start, latch cell_sel_i, nin_i, exp_tt_i and settle_i. Clear err_cnt_o, fail_valid_o, fail_vec_o, done_o, pass_o and cfg_err_o. Set vec = 0.
- If nin_i is 0 or greater than 4, or cell_sel_i >= NCELLS: go directly to DONE on the next cycle with cfg_err_o = 1 and pass_o = 0. cell_in_o stays 0.
- Otherwise go to APPLY.

APPLY (1 cycle):
- cell_in_o <= vec, zero-extended. Inputs at or above nin are driven 0.
- busy_o = 1. Go to SETTLE.

SETTLE (S cycles, S = latched settle_i):
- Down-counter. S = 0 skips this state: APPLY goes directly to SAMPLE.

SAMPLE (1 cycle):
- Compare cell_y_i[cell_sel] with exp_tt[vec].
- On mismatch: err_cnt_o increments. If fail_valid_o = 0, capture fail_vec_o <= vec and set fail_valid_o = 1.
- If vec == 2^nin - 1, go to DONE. Otherwise vec increments and go to APPLY.

Timing:
- Per-vector period is S+2 cycles.
- done_o rises exactly 2^nin × (S+2) + 1 cycles after the start_i edge.

DONE:
- busy_o = 0, done_o = 1, pass_o = (err_cnt_o == 0 and cfg_err_o == 0).
- cell_in_o returns to 0. Results hold until the next accepted start or reset.

abort_i:
- Takes priority over start_i and over all states.
- Go to IDLE next cycle; busy_o = 0, cell_in_o = 0, done_o = 0.
- err_cnt_o and fail fields keep their partial values.

Simultaneous events:
- wb_rst_i takes priority over abort_i, which takes priority over start_i.

Other rules:
- cell_sel_o is held stable for the whole run, so the mux never switches mid-vector.
- err_cnt_o cannot overflow: at most 16 vectors, 5 bits wide.

Test Plan:
1. NAND2 model (Y = ~(A&B)): nin = 2, exp_tt = 16'h0007, S = 0, start -> cell_in_o sequence 0,1,2,3; done_o at cycle 9 after start; pass_o = 1; err_cnt_o = 0.
2. Same setup with the model's Y stuck at 1 -> err_cnt_o = 1, fail_vec_o = 3, fail_valid_o = 1, pass_o = 0.
3. MUX2 model (nin = 3), S = 5, all vectors wrong (exp_tt inverted) -> err_cnt_o = 8, fail_vec_o = 0; done_o at cycle 8 × 7 + 1 = 57.
4. nin = 0, then nin = 5, then cell_sel = NCELLS -> each run: done_o next cycle, cfg_err_o = 1, pass_o = 0, cell_in_o never nonzero.
5. 4-input AOI22 model, nin = 4, abort_i asserted during vector 6 -> IDLE next cycle, busy_o = 0, done_o = 0; a second start_i pulse during the run is ignored; a fresh start yields 16 vectors and pass_o = 1.
6. wb_rst_i asserted during SETTLE, with start_i and abort_i also asserted the same cycle -> all outputs 0 the following cycle, FSM in IDLE.

Source files
------------

// File: rtl/cell_test_sequencer.sv
// Self-test sequencer for the standard-cell array: selects one cell, walks
// every input vector with a programmable settle time, samples the cell's Y
// and compares against a software-supplied truth table.
module cell_test_sequencer #(
  parameter int unsigned NCELLS   = 22,
  parameter int unsigned SELW     = 5,
  parameter int unsigned SETTLE_W = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [SELW-1:0]     cell_sel_i,
  input  logic [2:0]          nin_i,
  input  logic [15:0]         exp_tt_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic [NCELLS-1:0]   cell_y_i,
  output logic [3:0]          cell_in_o,
  output logic [SELW-1:0]     cell_sel_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                cfg_err_o,
  output logic [4:0]          err_cnt_o,
  output logic [3:0]          fail_vec_o,
  output logic                fail_valid_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state;
  logic [3:0]          vec;
  logic [2:0]          nin_q;
  logic [15:0]         tt_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_cnt;

  logic                cfg_bad_c;
  logic [3:0]          last_vec_c;
  logic                y_sel_c;
  logic                mismatch_c;

  // Highest vector index for a 1..4 input cell; doubles as the input mask
  function automatic logic [3:0] vec_mask(input logic [2:0] n);
    case (n)
      3'd1:    vec_mask = 4'h1;
      3'd2:    vec_mask = 4'h3;
      3'd3:    vec_mask = 4'h7;
      default: vec_mask = 4'hF;
    endcase
  endfunction

  // Configuration check on the live inputs at start time
  always_comb begin
    cfg_bad_c = 1'b0;
    if ((nin_i == 3'd0) || (nin_i > 3'd4)) begin
      cfg_bad_c = 1'b1;
    end
    if ({1'b0, cell_sel_i} >= (SELW+1)'(NCELLS)) begin
      cfg_bad_c = 1'b1;
    end
  end

  // Selected cell output and comparison against the latched truth table
  always_comb begin
    last_vec_c = vec_mask(nin_q);
    y_sel_c    = 1'b0;
    if ({1'b0, cell_sel_o} < (SELW+1)'(NCELLS)) begin
      y_sel_c = cell_y_i[cell_sel_o];
    end
    mismatch_c = (y_sel_c != tt_q[vec]);
  end

  // Sequencer FSM with registered outputs; reset > abort > start
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      vec          <= 4'd0;
      nin_q        <= 3'd0;
      tt_q         <= 16'd0;
      settle_q     <= '0;
      settle_cnt   <= '0;
      cell_in_o    <= 4'd0;
      cell_sel_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      cfg_err_o    <= 1'b0;
      err_cnt_o    <= 5'd0;
      fail_vec_o   <= 4'd0;
      fail_valid_o <= 1'b0;
    end else if (abort_i) begin
      // Partial error results are kept for software to inspect
      state     <= IDLE;
      busy_o    <= 1'b0;
      cell_in_o <= 4'd0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            done_o <= 1'b1;
            pass_o <= (err_cnt_o == 5'd0) && !cfg_err_o;
          end
          if (start_i) begin
            cell_sel_o   <= cell_sel_i;
            nin_q        <= nin_i;
            tt_q         <= exp_tt_i;
            settle_q     <= settle_i;
            vec          <= 4'd0;
            err_cnt_o    <= 5'd0;
            fail_vec_o   <= 4'd0;
            fail_valid_o <= 1'b0;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            cell_in_o    <= 4'd0;
            if (cfg_bad_c) begin
              cfg_err_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= DONE;
            end else begin
              cfg_err_o <= 1'b0;
              busy_o    <= 1'b1;
              state     <= APPLY;
            end
          end
        end

        APPLY: begin
          cell_in_o <= vec & last_vec_c;
          if (settle_q == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_q;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt <= SETTLE_W'(1)) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end

        SAMPLE: begin
          if (mismatch_c) begin
            err_cnt_o <= err_cnt_o + 5'd1;
            if (!fail_valid_o) begin
              fail_vec_o   <= vec;
              fail_valid_o <= 1'b1;
            end
          end
          if (vec == last_vec_c) begin
            busy_o    <= 1'b0;
            cell_in_o <= 4'd0;
            state     <= DONE;
          end else begin
            vec   <= vec + 4'd1;
            state <= APPLY;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Bench for cell_test_sequencer: behavioural cell models drive cell_y_i,
// expected vectors and run results are queued at start and compared as the
// sequencer produces them.
module tb_cell_test_sequencer;

  localparam int unsigned NCELLS   = 22;
  localparam int unsigned SELW     = 5;
  localparam int unsigned SETTLE_W = 8;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i = 1'b1;
  logic                start_i  = 1'b0;
  logic                abort_i  = 1'b0;
  logic [SELW-1:0]     cell_sel_i = '0;
  logic [2:0]          nin_i    = 3'd0;
  logic [15:0]         exp_tt_i = 16'd0;
  logic [SETTLE_W-1:0] settle_i = '0;
  logic [NCELLS-1:0]   cell_y_i;
  logic [3:0]          cell_in_o;
  logic [SELW-1:0]     cell_sel_o;
  logic                busy_o, done_o, pass_o, cfg_err_o, fail_valid_o;
  logic [4:0]          err_cnt_o;
  logic [3:0]          fail_vec_o;

  int errors = 0;
  int checks = 0;
  int cur_model = 0;
  int cur_sel   = 0;

  typedef struct {
    int err; int fvec; int fval; int pass; int cfg; int lat;
  } exp_t;
  exp_t res_q[$];
  int   vec_q[$];

  cell_test_sequencer #(.NCELLS(NCELLS), .SELW(SELW), .SETTLE_W(SETTLE_W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
    .cell_sel_i(cell_sel_i), .nin_i(nin_i), .exp_tt_i(exp_tt_i), .settle_i(settle_i),
    .cell_y_i(cell_y_i), .cell_in_o(cell_in_o), .cell_sel_o(cell_sel_o),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .cfg_err_o(cfg_err_o),
    .err_cnt_o(err_cnt_o), .fail_vec_o(fail_vec_o), .fail_valid_o(fail_valid_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // 0 NAND2, 1 stuck-at-1, 2 MUX2 (S=C), 3 AOI22
  function automatic logic model_y(input int mdl, input int v);
    logic [3:0] b;
    b = 4'(v);
    case (mdl)
      0:       model_y = ~(b[0] & b[1]);
      1:       model_y = 1'b1;
      2:       model_y = b[2] ? b[1] : b[0];
      default: model_y = ~((b[0] & b[1]) | (b[2] & b[3]));
    endcase
  endfunction

  // Selected cell follows the model; every other cell outputs the opposite
  always_comb begin
    logic y;
    y = model_y(cur_model, int'(cell_in_o));
    cell_y_i = {NCELLS{~y}};
    if (cur_sel < int'(NCELLS)) cell_y_i[cur_sel] = y;
  end

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cell_in"}, int'(cell_in_o), 0);
    chk({tag, "_sel"}, int'(cell_sel_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_pass"}, int'(pass_o), 0);
    chk({tag, "_cfg"}, int'(cfg_err_o), 0);
    chk({tag, "_errcnt"}, int'(err_cnt_o), 0);
    chk({tag, "_fvec"}, int'(fail_vec_o), 0);
    chk({tag, "_fval"}, int'(fail_valid_o), 0);
  endtask

  // One complete run: queue expectations, start, follow vectors, check results
  task automatic run(input int sel, input int nin, input logic [15:0] tt,
                     input int s, input int mdl, input string tag);
    exp_t e;
    int   nvec, c, limit;
    bit   bad, seen;
    bad  = (nin == 0) || (nin > 4) || (sel >= int'(NCELLS));
    nvec = bad ? 0 : (1 << nin);
    e = '{0, 0, 0, 0, 0, 0};
    for (int v = 0; v < nvec; v++) begin
      vec_q.push_back(v);
      if (model_y(mdl, v) != tt[v]) begin
        if (e.fval == 0) begin
          e.fvec = v;
          e.fval = 1;
        end
        e.err++;
      end
    end
    e.cfg  = bad ? 1 : 0;
    e.pass = (!bad && e.err == 0) ? 1 : 0;
    e.lat  = bad ? 1 : nvec * (s + 2) + 1;
    res_q.push_back(e);

    cur_model  = mdl;
    cur_sel    = sel;
    cell_sel_i = SELW'(sel);
    nin_i      = 3'(nin);
    exp_tt_i   = tt;
    settle_i   = SETTLE_W'(s);
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;

    c = 0;
    seen = 0;
    limit = e.lat + 20;
    while (!seen && c < limit) begin
      tick();
      c++;
      if (bad) begin
        chk({tag, "_cell_in_idle"}, int'(cell_in_o), 0);
      end else begin
        if (c == 1) chk({tag, "_busy"}, int'(busy_o), 1);
        if (((c - 1) % (s + 2)) == 0 && c <= nvec * (s + 2) && vec_q.size() > 0)
          chk({tag, "_vec"}, int'(cell_in_o), vec_q.pop_front());
      end
      if (done_o) seen = 1;
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    vec_q.delete();

    e = res_q.pop_front();
    chk({tag, "_latency"}, c, e.lat);
    chk({tag, "_errcnt"}, int'(err_cnt_o), e.err);
    chk({tag, "_fval"}, int'(fail_valid_o), e.fval);
    chk({tag, "_fvec"}, int'(fail_vec_o), e.fvec);
    chk({tag, "_pass"}, int'(pass_o), e.pass);
    chk({tag, "_cfg"}, int'(cfg_err_o), e.cfg);
    chk({tag, "_busy_end"}, int'(busy_o), 0);
    chk({tag, "_cell_in_end"}, int'(cell_in_o), 0);
    chk({tag, "_sel_out"}, int'(cell_sel_o), sel);
  endtask

  initial begin
    logic [15:0] aoi_tt;
    logic [15:0] aoi_bad;

    repeat (3) tick();
    chk_all_zero("reset");
    wb_rst_i = 1'b0;
    tick();

    // NAND2 good and with stuck-at-1 output
    run(3, 2, 16'h0007, 0, 0, "nand2");
    run(3, 2, 16'h0007, 0, 1, "nand2_stuck");

    // MUX2 against an inverted truth table (true table is 8'hCA)
    run(10, 3, 16'h0035, 5, 2, "mux2_inv");

    // Illegal configurations
    run(1, 0, 16'h0007, 0, 0, "cfg_nin0");
    run(1, 5, 16'h0007, 0, 0, "cfg_nin5");
    run(int'(NCELLS), 2, 16'h0007, 0, 0, "cfg_sel");

    // AOI22: abort during vector 6, ignored re-start, then a clean run
    for (int v = 0; v < 16; v++) aoi_tt[v] = model_y(3, v);
    aoi_bad = aoi_tt ^ 16'h0004;
    cur_model  = 3;
    cur_sel    = 7;
    cell_sel_i = SELW'(7);
    nin_i      = 3'd4;
    exp_tt_i   = aoi_bad;
    settle_i   = SETTLE_W'(1);
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      tick();
      start_i = (c == 3);
    end
    chk("abort_vec6", int'(cell_in_o), 6);
    chk("abort_busy_before", int'(busy_o), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_cell_in", int'(cell_in_o), 0);
    chk("abort_errcnt", int'(err_cnt_o), 1);
    chk("abort_fvec", int'(fail_vec_o), 2);
    chk("abort_fval", int'(fail_valid_o), 1);
    tick();
    chk("abort_idle_done", int'(done_o), 0);
    run(7, 4, aoi_tt, 1, 3, "aoi22");

    // Reset mid-SETTLE with start and abort asserted together
    cur_model  = 0;
    cur_sel    = 4;
    cell_sel_i = SELW'(4);
    nin_i      = 3'd2;
    exp_tt_i   = 16'h0007;
    settle_i   = SETTLE_W'(3);
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("pre_rst_busy", int'(busy_o), 1);
    wb_rst_i = 1'b1;
    start_i  = 1'b1;
    abort_i  = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    chk_all_zero("midrst");
    tick();
    chk("midrst_idle_busy", int'(busy_o), 0);
    run(4, 2, 16'h0007, 0, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
